vga_pixel_stage: RTL
====================

Name: vga_pixel_stage

Overview:
- Downstream consumer of the VGA sync counter.
- Takes the per-pixel horizontal/vertical counts and raw sync pulses, then generates 12-bit RGB from a selectable test pattern with an 8x8 cursor overlay.
- Delays the syncs so they stay aligned with the colour pipeline, and drives the DAC/connector pins directly.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- BAR_W, 80, colour-bar width in pixels (H_ACTIVE/8)
- CUR_SIZE, 8, cursor box edge in pixels

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- en  in  1  pixel-clock enable; one pixel per en cycle
- h_count  in  10  current pixel column from sync counter
- v_count  in  10  current row from sync counter
- hsync_in  in  1  horizontal sync, active-low
- vsync_in  in  1  vertical sync, active-low
- mode_sel  in  2  pattern select, sampled at frame start
- fg_color  in  12  {R,G,B} 4 bits each, for solid/checker modes
- cursor_x  in  10  cursor left column, sampled at frame start
- cursor_y  in  10  cursor top row, sampled at frame start
- cursor_en  in  1  cursor enable, sampled at frame start
- hsync_out  out  1  hsync delayed 2 en-cycles
- vsync_out  out  1  vsync delayed 2 en-cycles
- red / green / blue  out  4 each  pixel colour
- frame_count  out  8  frames since reset, wraps

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- All registers advance only on cycles with en=1. With en=0, every register holds.
- Reset values:
  - hsync_out=1, vsync_out=1 (inactive)
  - RGB=0, frame_count=0
  - Latched mode=0 and latched cursor_en=0
  - Cursor position=0, bar_idx=0, bar_px=0, both pipeline stages cleared (syncs 1, active 0)
- Frame start: en && h_count==0 && v_count==0.
  - Latch mode_sel, cursor_x, cursor_y and cursor_en.
  - frame_count+1, wrapping 255 to 0.
  - New settings apply from that pixel onward.
- Active video: h_count<H_ACTIVE && v_count<V_ACTIVE. Outside active video, RGB is forced to 0 regardless of mode or cursor.
- Pipeline:
  - Stage 1 registers coords, active flag, syncs, bar_idx.
  - Stage 2 registers final RGB and syncs.
  - Latency is exactly 2 en-cycles from input to output for both colour and sync.
- Bar counter:
  - At h_count==0, bar_idx=0 and bar_px=0.
  - Otherwise bar_px increments. When bar_px==BAR_W-1, bar_px goes to 0 and bar_idx increments, saturating at 7.
  - The bar colour for a pixel uses the bar_idx value that pairs with that pixel's h_count, i.e. column c maps to bar c/BAR_W.
- Modes (latched value):
  - 0 solid: RGB=fg_color.
  - 1 bars: R=bar_idx[2]?F:0, G=bar_idx[1]?F:0, B=bar_idx[0]?F:0.
  - 2 checker: (h_count[5]^v_count[5]) ? fg_color : 0.
  - 3 gradient: R=h_count[7:4]+frame_count[3:0] (mod 16), G=v_count[7:4], B=frame_count[7:4].
- Cursor:
  - Inside when cursor_en && x<=h<x+CUR_SIZE && y<=v<y+CUR_SIZE.
  - Bounds use 11-bit arithmetic, with no wrap at the 10-bit edge.
  - Inside and active: output is the bitwise inverse of the pattern colour.
  - A cursor partly off-screen shows only its visible part.
- Non-contiguous h_count (a jump) does not break the block: bar_idx resyncs at the next h_count==0.
- Reset asserted mid-frame: outputs return to reset values on the next clk, regardless of en. Normal output resumes 2 en-cycles after the first en with reset low. frame_count first increments at the next frame start.

Test Plan:
- Reset, then en every cycle with counts from a 800x525 sweep → hsync_out/vsync_out equal hsync_in/vsync_in delayed exactly 2 en-cycles; RGB=0 for h>=640 or v>=480.
- mode_sel=1 from frame start → columns 0..79 are RGB 000, columns 80..159 are 00F, and columns 560..639 are FFF, each seen 2 cycles late.
- mode_sel=2, fg_color=0xA5C → pixel (32,0) is A5C, pixel (32,32) is 000, pixel (0,0) is 000.
- Cursor: cursor_en=1, (100,50) on mode 0 with fg=0x123 → pixels (100..107, 50..57) are EDC, pixel (108,50) is 123. Changing cursor_x mid-frame has no effect until the next frame start.
- en toggled 1/0 alternately → outputs change only on en cycles; latency is 2 en-cycles, not 2 clocks.
- Run 257 frame starts → frame_count wraps to 1. Reset mid-line → hsync_out=1, RGB=0, frame_count=0 next clk.

Source files
------------

// File: rtl/vga_pixel_stage.sv
// vga_pixel_stage: turns sync-counter coordinates into 12-bit test-pattern RGB
// with an 8x8 inverting cursor, and delays the syncs to match the colour path.
module vga_pixel_stage #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int BAR_W    = 80,
   parameter int CUR_SIZE = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [9:0]  h_count,
   input  logic [9:0]  v_count,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic [1:0]  mode_sel,
   input  logic [11:0] fg_color,
   input  logic [9:0]  cursor_x,
   input  logic [9:0]  cursor_y,
   input  logic        cursor_en,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic [3:0]  red,
   output logic [3:0]  green,
   output logic [3:0]  blue,
   output logic [7:0]  frame_count
);

   localparam int               PX_W    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
   localparam logic [10:0]      H_LIM   = 11'(H_ACTIVE);
   localparam logic [10:0]      V_LIM   = 11'(V_ACTIVE);
   localparam logic [10:0]      CUR_EXT = 11'(CUR_SIZE);
   localparam logic [PX_W-1:0]  PX_LAST = PX_W'(BAR_W - 1);
   localparam logic [PX_W-1:0]  PX_ONE  = PX_W'(1);

   // Bar index stops at the last bar instead of wrapping into bar 0.
   function automatic logic [2:0] bar_sat_inc(input logic [2:0] idx);
      return (idx == 3'd7) ? idx : idx + 3'd1;
   endfunction

   // Cursor span test in 11 bits so a box near column 1023 never wraps to 0.
   function automatic logic in_span(input logic [9:0] pos, input logic [9:0] start);
      logic [10:0] p;
      logic [10:0] s;
      p = {1'b0, pos};
      s = {1'b0, start};
      return (p >= s) && (p < s + CUR_EXT);
   endfunction

   logic              frame_start;
   logic              active_in;
   logic [1:0]        mode_q;
   logic [9:0]        cur_x_q;
   logic [9:0]        cur_y_q;
   logic              cur_en_q;
   logic [7:0]        frame_cnt_q;
   logic [2:0]        bar_idx_q;
   logic [PX_W-1:0]   bar_px_q;
   logic [2:0]        bar_idx_cur;
   logic [PX_W-1:0]   bar_px_cur;

   logic [9:0]        h_p1;
   logic [9:0]        v_p1;
   logic              active_p1;
   logic              hs_p1;
   logic              vs_p1;
   logic [2:0]        bar_idx_p1;
   logic [11:0]       fg_p1;

   logic [11:0]       pat_color;
   logic              in_cursor;
   logic [11:0]       pix_color;

   logic [11:0]       rgb_p2;
   logic              hs_p2;
   logic              vs_p2;

   assign frame_start = en && (h_count == 10'd0) && (v_count == 10'd0);
   assign active_in   = ({1'b0, h_count} < H_LIM) && ({1'b0, v_count} < V_LIM);

   // Frame-start latching of pattern/cursor settings and the frame counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q      <= 2'd0;
         cur_x_q     <= 10'd0;
         cur_y_q     <= 10'd0;
         cur_en_q    <= 1'b0;
         frame_cnt_q <= 8'd0;
      end else if (frame_start) begin
         mode_q      <= mode_sel;
         cur_x_q     <= cursor_x;
         cur_y_q     <= cursor_y;
         cur_en_q    <= cursor_en;
         frame_cnt_q <= frame_cnt_q + 8'd1;
      end
   end

   // Bar position for the pixel currently at the input; restarts on every column 0.
   always_comb begin
      bar_idx_cur = bar_idx_q;
      bar_px_cur  = bar_px_q + PX_ONE;
      if (h_count == 10'd0) begin
         bar_idx_cur = 3'd0;
         bar_px_cur  = '0;
      end else if (bar_px_q == PX_LAST) begin
         bar_idx_cur = bar_sat_inc(bar_idx_q);
         bar_px_cur  = '0;
      end
   end

   // ---- stage 1: register coordinates, active flag, syncs and bar index ----
   always_ff @(posedge clk) begin
      if (reset) begin
         bar_idx_q  <= 3'd0;
         bar_px_q   <= '0;
         h_p1       <= 10'd0;
         v_p1       <= 10'd0;
         active_p1  <= 1'b0;
         hs_p1      <= 1'b1;
         vs_p1      <= 1'b1;
         bar_idx_p1 <= 3'd0;
         fg_p1      <= 12'h000;
      end else if (en) begin
         bar_idx_q  <= bar_idx_cur;
         bar_px_q   <= bar_px_cur;
         h_p1       <= h_count;
         v_p1       <= v_count;
         active_p1  <= active_in;
         hs_p1      <= hsync_in;
         vs_p1      <= vsync_in;
         bar_idx_p1 <= bar_idx_cur;
         fg_p1      <= fg_color;
      end
   end

   // Pattern colour, cursor inversion and blanking for the stage-1 pixel.
   always_comb begin
      pat_color = fg_p1;
      case (mode_q)
         2'd0: pat_color = fg_p1;
         2'd1: pat_color = {{4{bar_idx_p1[2]}}, {4{bar_idx_p1[1]}}, {4{bar_idx_p1[0]}}};
         2'd2: pat_color = (h_p1[5] ^ v_p1[5]) ? fg_p1 : 12'h000;
         default: pat_color = {4'(h_p1[7:4] + frame_cnt_q[3:0]), v_p1[7:4], frame_cnt_q[7:4]};
      endcase
      in_cursor = cur_en_q && in_span(h_p1, cur_x_q) && in_span(v_p1, cur_y_q);
      pix_color = 12'h000;
      if (active_p1) begin
         pix_color = in_cursor ? ~pat_color : pat_color;
      end
   end

   // ---- stage 2: register final colour and syncs driving the pins ----
   always_ff @(posedge clk) begin
      if (reset) begin
         rgb_p2 <= 12'h000;
         hs_p2  <= 1'b1;
         vs_p2  <= 1'b1;
      end else if (en) begin
         rgb_p2 <= pix_color;
         hs_p2  <= hs_p1;
         vs_p2  <= vs_p1;
      end
   end

   assign hsync_out   = hs_p2;
   assign vsync_out   = vs_p2;
   assign red         = rgb_p2[11:8];
   assign green       = rgb_p2[7:4];
   assign blue        = rgb_p2[3:0];
   assign frame_count = frame_cnt_q;

endmodule
